// File: rtl/led_pwm_controller.sv
// led_pwm_controller: AXI4-Lite register bank driving glitch-free PWM LEDs with optional blink gating
module led_pwm_controller #(
  parameter int NUM_LEDS = 4,
  parameter int PWM_WIDTH = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [NUM_LEDS-1:0]             led_out,
  output logic                            pwm_sync
);
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  logic [NUM_LEDS-1:0] enable_r, mode_r, pwm_on, led_next;
  logic [31:0] blink_period, prescaler, wmask, rd_mux;
  logic blink_phase, wr_acc, rd_acc, wr_blink, wrap, unused_ok;
  logic [PWM_WIDTH-1:0] cnt;
  logic [PWM_WIDTH-1:0] duty [NUM_LEDS];
  logic [PWM_WIDTH-1:0] shadow [NUM_LEDS];
  logic [IW-1:0] widx, ridx;
  function automatic logic [31:0] mrg(input logic [31:0] old);
    return (old & ~wmask) | (s_axi_wdata & wmask);
  endfunction
  assign wmask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}}, {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};
  assign widx = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ridx = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_acc = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_acc = s_axi_arready & s_axi_arvalid;
  assign wr_blink = wr_acc & (widx == IW'(2));
  assign wrap = &cnt;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  always_comb begin
    rd_mux = ridx == IW'(0) ? 32'(enable_r) :
             ridx == IW'(1) ? 32'(mode_r) :
             ridx == IW'(2) ? blink_period :
             ridx == IW'(3) ? (32'(led_out) | {blink_phase, 31'b0}) : 32'b0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (ridx == IW'(4 + i)) rd_mux = 32'(duty[i]);
      pwm_on[i] = (cnt < shadow[i]) | (&shadow[i]);
    end
    led_next = enable_r & pwm_on & (~mode_r | {NUM_LEDS{blink_phase}});
  end
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s_axi_awready <= 1'b0;
      s_axi_wready <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      enable_r <= '0;
      mode_r <= '0;
      blink_period <= '0;
      prescaler <= '0;
      blink_phase <= 1'b1;
      cnt <= '0;
      pwm_sync <= 1'b0;
      led_out <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      s_axi_awready <= ~s_axi_awready & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
      s_axi_wready <= ~s_axi_awready & s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid;
      s_axi_bvalid <= wr_acc | (s_axi_bvalid & ~s_axi_bready);
      s_axi_arready <= ~s_axi_arready & s_axi_arvalid & ~s_axi_rvalid;
      s_axi_rvalid <= rd_acc | (s_axi_rvalid & ~s_axi_rready);
      if (rd_acc) s_axi_rdata <= rd_mux;
      if (wr_acc && widx == IW'(0)) enable_r <= NUM_LEDS'(mrg(32'(enable_r)));
      if (wr_acc && widx == IW'(1)) mode_r <= NUM_LEDS'(mrg(32'(mode_r)));
      if (wr_blink) blink_period <= mrg(blink_period);
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_acc && widx == IW'(4 + i)) duty[i] <= PWM_WIDTH'(mrg(32'(duty[i])));
        if (wrap) shadow[i] <= duty[i];
      end
      cnt <= cnt + 1'b1;
      pwm_sync <= wrap;
      if (blink_period == 32'd0) begin
        prescaler <= '0;
        blink_phase <= 1'b1;
      end else if (wr_blink) begin
        prescaler <= '0;
      end else if (prescaler == blink_period - 32'd1) begin
        prescaler <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        prescaler <= prescaler + 32'd1;
      end
      led_out <= led_next;
    end
  end
endmodule

// File: tb/tb_led_pwm_controller.sv
// tb_led_pwm_controller: register-map vectors, PWM/blink timing and handshake corner cases
module tb_led_pwm_controller;
  logic tb_ACLK = 1'b0;
  logic tb_ARESET;
  logic [6:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0] s_axi_awprot, s_axi_arprot;
  logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0] s_axi_wstrb;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rvalid, s_axi_rready;
  logic [3:0] led_out;
  logic pwm_sync;
  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];

  always #5 tb_ACLK = ~tb_ACLK;

  led_pwm_controller dut (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .led_out(led_out), .pwm_sync(pwm_sync)
  );

  typedef struct {
    bit          wr;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [6:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wr_issue(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 0;
    @(negedge tb_ACLK);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awvalid = 1; s_axi_wvalid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge tb_ACLK);
      ok = s_axi_awready && s_axi_wready;
    end
    check("wr_accept", 64'(ok), 64'd1);
    @(posedge tb_ACLK); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0;
  endtask

  task automatic wr_resp();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge tb_ACLK);
      ok = s_axi_bvalid;
    end
    check("bvalid", 64'(ok), 64'd1);
    check("bresp", 64'(s_axi_bresp), 64'd0);
    s_axi_bready = 1;
    @(posedge tb_ACLK); #1;
    s_axi_bready = 0;
  endtask

  task automatic rd_issue(input logic [6:0] a);
    bit ok;
    ok = 0;
    @(negedge tb_ACLK);
    s_axi_araddr = a; s_axi_arvalid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge tb_ACLK);
      ok = s_axi_arready;
    end
    check("rd_accept", 64'(ok), 64'd1);
    @(posedge tb_ACLK); #1;
    s_axi_arvalid = 0;
  endtask

  task automatic rd_resp();
    bit ok;
    logic [31:0] e;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge tb_ACLK);
      ok = s_axi_rvalid;
    end
    check("rvalid", 64'(ok), 64'd1);
    check("rresp", 64'(s_axi_rresp), 64'd0);
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
    check("rdata", 64'(s_axi_rdata), 64'(e));
    s_axi_rready = 1;
    @(posedge tb_ACLK); #1;
    s_axi_rready = 0;
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_issue(a, d, s);
    wr_resp();
  endtask

  task automatic axi_read(input logic [6:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    rd_issue(a);
    rd_resp();
  endtask

  task automatic do_reset();
    tb_ARESET = 1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 0;
  endtask

  task automatic wait_sync();
    bit ok;
    ok = 0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge tb_ACLK);
      ok = pwm_sync;
    end
    check("sync_seen", 64'(ok), 64'd1);
  endtask

  task automatic measure(output int highs, output int rises, output int syncs);
    logic p;
    p = led_out[0]; highs = 0; rises = 0; syncs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge tb_ACLK);
      highs += int'(led_out[0]);
      rises += int'(led_out[0] & ~p);
      syncs += int'(pwm_sync);
      p = led_out[0];
    end
  endtask

  task automatic wait_toggle(output int n);
    logic p;
    p = led_out[0]; n = 0;
    for (int i = 1; i <= 1100 && n == 0; i++) begin
      @(negedge tb_ACLK);
      if (led_out[0] !== p) n = i;
    end
  endtask

  initial begin
    int h, r, s, n;
    s_axi_awaddr = 0; s_axi_araddr = 0; s_axi_awprot = 0; s_axi_arprot = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0; s_axi_bready = 0; s_axi_rready = 0;
    tb_ARESET = 1;
    #12;
    check("rst_handshake", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 64'd0);
    check("rst_led", 64'(led_out), 64'd0);
    check("rst_sync", 64'(pwm_sync), 64'd0);
    @(negedge tb_ACLK);
    tb_ARESET = 0;

    vt[0]  = '{0, 7'h00, 32'h0,        4'h0, 7'h00, 32'h0};
    vt[1]  = '{0, 7'h00, 32'h0,        4'h0, 7'h08, 32'h0};
    vt[2]  = '{0, 7'h00, 32'h0,        4'h0, 7'h0C, 32'h80000000};
    vt[3]  = '{1, 7'h00, 32'h0101FFFF, 4'hF, 7'h00, 32'h0000000F};
    vt[4]  = '{1, 7'h04, 32'hABCD0001, 4'hF, 7'h04, 32'h00000001};
    vt[5]  = '{1, 7'h08, 32'hDEAD0011, 4'hF, 7'h08, 32'hDEAD0011};
    vt[6]  = '{1, 7'h0C, 32'hBEEF0011, 4'hF, 7'h0C, 32'h80000000};
    vt[7]  = '{1, 7'h08, 32'h12345678, 4'hF, 7'h08, 32'h12345678};
    vt[8]  = '{1, 7'h08, 32'hFFFFFFFF, 4'h1, 7'h08, 32'h123456FF};
    vt[9]  = '{1, 7'h10, 32'hFFFF1234, 4'hF, 7'h10, 32'h00000034};
    vt[10] = '{1, 7'h14, 32'h0000AB00, 4'h2, 7'h14, 32'h00000000};
    vt[11] = '{1, 7'h40, 32'hFFFFFFFF, 4'hF, 7'h40, 32'h00000000};
    vt[12] = '{1, 7'h04, 32'hFFFFFFFF, 4'hF, 7'h04, 32'h0000000F};
    vt[13] = '{1, 7'h1C, 32'h0000005A, 4'hF, 7'h1C, 32'h0000005A};
    vt[14] = '{1, 7'h00, 32'h00000000, 4'hF, 7'h00, 32'h00000000};
    foreach (vt[i]) begin
      if (vt[i].wr) axi_write(vt[i].wa, vt[i].wd, vt[i].ws);
      axi_read(vt[i].ra, vt[i].exp);
    end

    // read and write to the same register accepted together: read sees the old value
    @(negedge tb_ACLK);
    s_axi_awaddr = 7'h1C; s_axi_wdata = 32'h33; s_axi_wstrb = 4'hF; s_axi_araddr = 7'h1C;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    @(negedge tb_ACLK);
    check("same_cycle_accept", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd7);
    @(posedge tb_ACLK); #1;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    exp_q.push_back(32'h5A);
    wr_resp();
    rd_resp();
    axi_read(7'h1C, 32'h33);

    do_reset();
    axi_write(7'h00, 32'h1, 4'hF);
    axi_write(7'h10, 32'h40, 4'hF);
    wait_sync();
    measure(h, r, s);
    check("duty40_highs", 64'(h), 64'd64);
    check("duty40_rises", 64'(r), 64'd1);
    check("sync_once_per_period", 64'(s), 64'd1);
    check("sync_period_end", 64'(pwm_sync), 64'd1);

    repeat (80) @(negedge tb_ACLK);
    axi_write(7'h10, 32'h80, 4'hF);
    h = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge tb_ACLK);
      h += int'(led_out[0]);
      if (pwm_sync) break;
    end
    check("no_runt_before_sync", 64'(h), 64'd0);
    measure(h, r, s);
    check("duty80_highs", 64'(h), 64'd128);
    check("duty80_rises", 64'(r), 64'd1);

    axi_write(7'h10, 32'hFF, 4'hF);
    wait_sync();
    measure(h, r, s);
    check("dutyFF_highs", 64'(h), 64'd256);

    axi_write(7'h04, 32'h1, 4'hF);
    axi_write(7'h08, 32'd512, 4'hF);
    wait_toggle(n);
    check("blink_first_toggle", 64'(n != 0), 64'd1);
    wait_toggle(n);
    check("blink_half_period_a", 64'(n), 64'd512);
    wait_toggle(n);
    check("blink_half_period_b", 64'(n), 64'd512);
    axi_write(7'h08, 32'd0, 4'hF);
    repeat (3) @(negedge tb_ACLK);
    h = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge tb_ACLK);
      h += int'(led_out[0]);
    end
    check("blink_off_steady", 64'(h), 64'd600);

    // responses held with bready/rready low while fresh requests wait
    wr_issue(7'h1C, 32'hA5, 4'hF);
    rd_issue(7'h1C);
    s_axi_awaddr = 7'h00; s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_araddr = 7'h00; s_axi_arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge tb_ACLK);
      check("hold", {s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready, s_axi_bresp, s_axi_rresp, s_axi_rdata},
            {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 32'hA5});
    end
    #2 tb_ARESET = 1;
    #1;
    check("async_reset_outputs", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                                       led_out, pwm_sync, s_axi_rdata}), 64'd0);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    @(negedge tb_ACLK);
    tb_ARESET = 0;
    @(negedge tb_ACLK);
    check("first_edge_accept", 64'(s_axi_arready), 64'd1);
    @(posedge tb_ACLK); #1;
    s_axi_arvalid = 0;
    exp_q.push_back(32'h0);
    rd_resp();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
